// File: rtl/uart_rxq.sv
// Receive byte queue between a UART receiver and a bus: circular buffer with a
// separate level counter, sticky overflow flag and a level-threshold interrupt.
module uart_rxq #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [31:0]              out_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW + 1)'(THRESH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // Handshake: neither side can be stalled. in_valid is a one-cycle strobe
    // that is always consumed (stored, or dropped when full with no pop);
    // each rd_en cycle pops the head if one exists, otherwise it is ignored.
    // A pop at full frees the slot the simultaneous push needs.
    always_comb begin
        do_pop  = rd_en && !empty;
        do_push = in_valid && (!full || do_pop);
        drop    = in_valid && !do_push;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        empty    = (level == '0);
        full     = (level == DEPTH_L);
        irq      = (level >= THRESH_L);
        out_data = empty ? 32'hFFFF_FFFF : {24'h0, mem[rp]};
    end

endmodule
